// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
//   Shared types and default constants for the fetch program-counter
//   sequencer.
//   - pc_state_e   : sequencer FSM encoding (BOOT, RUN, REDIR), 2 bits
//   - RESET_PC_DEF : default PC after reset
//   - INC_DEF      : default sequential increment in bytes
//   - TRAP_PC_DEF  : default vector for misaligned redirect targets
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INC_DEF      = 4;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_adder.sv
// -----------------------------------------------------------------------------
// pc_sequencer_adder
//   Plain modulo-2^WIDTH adder used to form the sequential next PC.
//   Carry out is dropped on purpose: the PC wraps silently.
// Ports:
//   a   in  WIDTH  first operand (current PC)
//   b   in  WIDTH  second operand (increment)
//   sum out WIDTH  a + b, truncated to WIDTH bits
// -----------------------------------------------------------------------------
module pc_sequencer_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter register and fetch-request generator for the front end.
//   Issues pc as a valid/ready request to instruction memory, advances by INC
//   on each accepted request, and follows branch/jump redirects. While a
//   request is held (valid but not accepted) the pc is frozen and the
//   youngest redirect is parked in a pending register until acceptance.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   defined   : a selected redirect target with target[1:0] != 0 is replaced
//               by TRAP_PC and misalign pulses for one cycle after selection.
//   undefined : target[1:0] is forced to 2'b00, misalign is tied to 0.
//
// Ports:
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   stall          in   1      hazard stall, blocks acceptance
//   branch_taken   in   1      redirect pulse from execute
//   branch_target  in   WIDTH  branch destination
//   jump           in   1      redirect pulse from decode (wins over branch)
//   jump_target    in   WIDTH  jump destination
//   fetch_ready    in   1      instruction memory accepts the request
//   fetch_valid    out  1      request valid
//   pc             out  WIDTH  fetch address
//   pc_plus_inc    out  WIDTH  pc + INC, combinational (link value)
//   misalign       out  1      misaligned redirect target seen
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int               INC      = INC_DEF,
    parameter logic [WIDTH-1:0] TRAP_PC  = WIDTH'(TRAP_PC_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             misalign
);

    localparam logic [1:0]       ST_BOOT  = BOOT;
    localparam logic [1:0]       ST_RUN   = RUN;
    localparam logic [1:0]       ST_REDIR = REDIR;
    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] pc_q, pc_nxt;
    logic [WIDTH-1:0] pend_pc, pend_nxt;
    logic [WIDTH-1:0] raw_target, target;
    logic             redir, accept;

    // ------------------------------------------------------------------
    // Sequential next PC comes from the shared adder instance.
    // ------------------------------------------------------------------
    pc_sequencer_adder #(
        .WIDTH (WIDTH)
    ) u_inc (
        .a   (pc_q),
        .b   (INC_W),
        .sum (pc_plus_inc)
    );

    assign pc          = pc_q;
    assign fetch_valid = (state != ST_BOOT);
    assign accept      = fetch_valid & fetch_ready & ~stall;

    // Decode is younger than execute in program order only if both fire
    // together because execute is flushing; jump still wins here since the
    // execute-side flush of decode is handled downstream.
    assign redir      = jump | branch_taken;
    assign raw_target = jump ? jump_target : branch_target;

`ifdef PC_ALIGN_CHECK_EN
    logic bad_align;
    logic misalign_q;

    assign bad_align = |raw_target[1:0];
    assign target    = bad_align ? TRAP_PC : raw_target;

    // Every redirect is either loaded or parked in the same cycle, so the
    // pulse simply follows any misaligned redirect by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= redir & bad_align;
    end

    assign misalign = misalign_q;
`else
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    assign target   = raw_target & ALIGN_MASK;
    assign misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-PC / pending selection.
    // pc only moves on acceptance, except out of BOOT where no request
    // is outstanding yet.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        pend_nxt  = pend_pc;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_RUN;
                if (redir) pc_nxt = target;
            end
            ST_RUN: begin
                if (accept) begin
                    pc_nxt = redir ? target : pc_plus_inc;
                end else if (redir) begin
                    pend_nxt  = target;
                    state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (accept) begin
                    // A fresh redirect is younger than the parked one.
                    pc_nxt    = redir ? target : pend_pc;
                    state_nxt = ST_RUN;
                end else if (redir) begin
                    pend_nxt = target;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_BOOT;
            pc_q    <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. Each accepted handshake pops the
//   next expected fetch address from the scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        misalign;

    int vecs = 0;
    int errs = 0;
    logic [31:0] sb[$];

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_B   = 32'h0000_0080;
    localparam logic [31:0] EXP_J   = 32'h0000_0080;
    localparam logic        EXP_MIS = 1'b1;
`else
    localparam logic [31:0] EXP_B   = 32'h0000_0100;
    localparam logic [31:0] EXP_J   = 32'h0000_0200;
    localparam logic        EXP_MIS = 1'b0;
`endif

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .pc            (pc),
        .pc_plus_inc   (pc_plus_inc),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; the scoreboard is consumed at
    // the negedge, when the upcoming edge's handshake is already decided.
    task automatic cycle();
        logic [31:0] exp;
        @(negedge clk);
        if (rst_n && fetch_valid && fetch_ready && !stall) begin
            vecs++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL accept_unexpected: pc=%h, no request expected", pc);
            end else begin
                exp = sb.pop_front();
                if (pc !== exp) begin
                    errs++;
                    $display("FAIL accept_pc: got %h, want %h", pc, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0; fetch_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (pc !== 32'h0) begin errs++; $display("FAIL reset_pc: got %h, want 0", pc); end
        vecs++; if (fetch_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b, want 0", fetch_valid); end
        vecs++; if (misalign !== 1'b0) begin errs++; $display("FAIL reset_misalign: got %b, want 0", misalign); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        vecs++; if (fetch_valid !== 1'b0) begin errs++; $display("FAIL boot_valid: got %b, want 0", fetch_valid); end
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
        repeat (5) cycle();
        fetch_ready = 1'b0;
        vecs++; if (pc !== 32'h10) begin errs++; $display("FAIL seq_pc: got %h, want 10", pc); end
        vecs++; if (sb.size() != 0) begin errs++; $display("FAIL seq_drain: got %0d left, want 0", sb.size()); end
    endtask

    task automatic test_hold_branch();
        cycle();
        vecs++; if (pc !== 32'h10 || fetch_valid !== 1'b1) begin errs++; $display("FAIL hold1: got pc=%h v=%b, want 10/1", pc, fetch_valid); end
        branch_taken = 1'b1; branch_target = 32'h200;
        cycle();
        branch_taken = 1'b0;
        vecs++; if (pc !== 32'h10) begin errs++; $display("FAIL hold2: got %h, want 10", pc); end
        cycle();
        vecs++; if (pc !== 32'h10 || fetch_valid !== 1'b1) begin errs++; $display("FAIL hold3: got pc=%h v=%b, want 10/1", pc, fetch_valid); end
        fetch_ready = 1'b1;
        sb.push_back(32'h10); sb.push_back(32'h200); sb.push_back(32'h204);
        cycle();
        vecs++; if (pc !== 32'h200) begin errs++; $display("FAIL pend_load: got %h, want 200", pc); end
        cycle(); cycle();
        fetch_ready = 1'b0;
        vecs++; if (pc !== 32'h208) begin errs++; $display("FAIL post_branch: got %h, want 208", pc); end
    endtask

    task automatic test_priority();
        fetch_ready = 1'b1;
        jump = 1'b1; jump_target = 32'h400;
        branch_taken = 1'b1; branch_target = 32'h300;
        sb.push_back(32'h208);
        cycle();
        jump = 1'b0; branch_taken = 1'b0; fetch_ready = 1'b0;
        vecs++; if (pc !== 32'h400) begin errs++; $display("FAIL jump_priority: got %h, want 400", pc); end
    endtask

    task automatic test_stall_redir();
        fetch_ready = 1'b1; stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h500;
        cycle();
        vecs++; if (pc !== 32'h400 || fetch_valid !== 1'b1) begin errs++; $display("FAIL stall_hold: got pc=%h v=%b, want 400/1", pc, fetch_valid); end
        branch_target = 32'h600;
        cycle();
        branch_taken = 1'b0; stall = 1'b0;
        vecs++; if (pc !== 32'h400) begin errs++; $display("FAIL stall_hold2: got %h, want 400", pc); end
        sb.push_back(32'h400); sb.push_back(32'h600);
        cycle();
        vecs++; if (pc !== 32'h600) begin errs++; $display("FAIL youngest_wins: got %h, want 600", pc); end
        cycle();
        fetch_ready = 1'b0;
        vecs++; if (pc !== 32'h604) begin errs++; $display("FAIL after_pend: got %h, want 604", pc); end
        // Parked redirect overridden by a redirect in the accepting cycle.
        branch_taken = 1'b1; branch_target = 32'h700;
        cycle();
        branch_taken = 1'b0;
        fetch_ready = 1'b1; jump = 1'b1; jump_target = 32'h800;
        sb.push_back(32'h604);
        cycle();
        jump = 1'b0; fetch_ready = 1'b0;
        vecs++; if (pc !== 32'h800) begin errs++; $display("FAIL redir_override: got %h, want 800", pc); end
    endtask

    task automatic test_wrap();
        fetch_ready = 1'b1; jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        sb.push_back(32'h800);
        cycle();
        jump = 1'b0;
        vecs++; if (pc_plus_inc !== 32'h0) begin errs++; $display("FAIL wrap_inc: got %h, want 0", pc_plus_inc); end
        sb.push_back(32'hFFFF_FFFC);
        cycle();
        fetch_ready = 1'b0;
        vecs++; if (pc !== 32'h0 || pc_plus_inc !== 32'h4) begin errs++; $display("FAIL wrap_pc: got %h/%h, want 0/4", pc, pc_plus_inc); end
    endtask

    task automatic test_reset_mid();
        branch_taken = 1'b1; branch_target = 32'h900;
        cycle();
        branch_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (pc !== 32'h0 || fetch_valid !== 1'b0) begin errs++; $display("FAIL async_reset: got pc=%h v=%b, want 0/0", pc, fetch_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1; fetch_ready = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4);
        repeat (3) cycle();
        fetch_ready = 1'b0;
        vecs++; if (pc !== 32'h8) begin errs++; $display("FAIL pend_discard: got %h, want 8", pc); end
        // Redirect taken straight out of BOOT.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; branch_taken = 1'b1; branch_target = 32'hA00;
        cycle();
        branch_taken = 1'b0;
        vecs++; if (pc !== 32'hA00 || fetch_valid !== 1'b1) begin errs++; $display("FAIL boot_redir: got pc=%h v=%b, want a00/1", pc, fetch_valid); end
    endtask

    task automatic test_align();
        fetch_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h102;
        sb.push_back(32'hA00);
        cycle();
        branch_taken = 1'b0; fetch_ready = 1'b0;
        vecs++; if (pc !== EXP_B) begin errs++; $display("FAIL align_pc: got %h, want %h", pc, EXP_B); end
        vecs++; if (misalign !== EXP_MIS) begin errs++; $display("FAIL align_pulse: got %b, want %b", misalign, EXP_MIS); end
        cycle();
        vecs++; if (misalign !== 1'b0) begin errs++; $display("FAIL align_clear: got %b, want 0", misalign); end
        jump = 1'b1; jump_target = 32'h203;
        cycle();
        jump = 1'b0;
        vecs++; if (misalign !== EXP_MIS || pc !== EXP_B) begin errs++; $display("FAIL align_park: got m=%b pc=%h, want %b/%h", misalign, pc, EXP_MIS, EXP_B); end
        fetch_ready = 1'b1;
        sb.push_back(EXP_B);
        cycle();
        fetch_ready = 1'b0;
        vecs++; if (pc !== EXP_J || misalign !== 1'b0) begin errs++; $display("FAIL align_pend: got pc=%h m=%b, want %h/0", pc, misalign, EXP_J); end
        vecs++; if (sb.size() != 0) begin errs++; $display("FAIL final_drain: got %0d left, want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_hold_branch();
        test_priority();
        test_stall_redir();
        test_wrap();
        test_reset_mid();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
